// File: rtl/lmul_group_sequencer.sv
// LMUL register-group sequencer: expands one vector ALU
// instruction into a stream of per-register micro-ops.
module lmul_group_sequencer #(
  parameter int NREGS    = 32,
  parameter int IDX_W    = 5,
  parameter int MAX_LMUL = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] raA,
  input  logic [IDX_W-1:0] raB,
  input  logic [IDX_W-1:0] rdest,
  input  logic [2:0]       lmul_enc,
  input  logic             widen,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] raA_out,
  output logic [IDX_W-1:0] raB_out,
  output logic [IDX_W-1:0] rdest_out,
  output logic [CNT_W-1:0] uop_idx,
  output logic             uop_last,
  output logic             illegal,
  output logic             fetch_stall
);

  localparam int SW = CNT_W + 1;

  typedef enum logic {
    IDLE,
    EXPAND
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] k;
  logic [CNT_W-1:0] n_last;
  logic [IDX_W-1:0] base_a;
  logic [IDX_W-1:0] base_b;
  logic [IDX_W-1:0] base_d;
  logic             wide_q;

  logic [SW-1:0]    lmul_sz;
  logic [SW-1:0]    emul_sz;
  logic             rsvd;
  logic             too_big;
  logic             wide_max;
  logic [IDX_W-1:0] mask_l;
  logic [IDX_W-1:0] mask_e;
  logic             misal;
  logic             dec_ill;
  logic [CNT_W-1:0] dec_last;

  logic [CNT_W-1:0] k_nx;
  logic [CNT_W-1:0] src_off;
  logic             accept;
  logic             fire;

  // Decode group size, beat count and legality of the offered instruction
  always_comb begin
    lmul_sz = SW'(1);
    rsvd    = 1'b0;
    unique case (1'b1)
      (lmul_enc == 3'b001): lmul_sz = SW'(2);
      (lmul_enc == 3'b010): lmul_sz = SW'(4);
      (lmul_enc == 3'b011): lmul_sz = SW'(8);
      (lmul_enc == 3'b100): rsvd    = 1'b1;
      default:              lmul_sz = SW'(1);
    endcase
    emul_sz  = widen ? (lmul_sz << 1) : lmul_sz;
    too_big  = lmul_sz > SW'(MAX_LMUL);
    wide_max = widen && (lmul_sz == SW'(MAX_LMUL));
    mask_l   = IDX_W'(lmul_sz - SW'(1));
    mask_e   = IDX_W'(emul_sz - SW'(1));
    misal    = (|(raA & mask_l))
             | (|(raB & mask_l))
             | (|(rdest & mask_e));
    dec_ill  = rsvd | too_big | wide_max | misal;
    dec_last = CNT_W'(emul_sz - SW'(1));
  end

  // Next-beat offsets; widened sources advance every other beat
  always_comb begin
    k_nx    = k + CNT_W'(1);
    src_off = wide_q ? (k_nx >> 1) : k_nx;
  end

  assign out_valid   = (state == EXPAND);
  assign uop_idx     = k;
  assign in_ready    = !out_valid || (out_ready && uop_last);
  assign fetch_stall = out_valid && !uop_last;
  assign accept      = in_valid && in_ready;
  assign fire        = out_valid && out_ready;

  // Expansion FSM with the registered micro-op output stage
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= IDLE;
      k         <= '0;
      n_last    <= '0;
      base_a    <= '0;
      base_b    <= '0;
      base_d    <= '0;
      wide_q    <= 1'b0;
      raA_out   <= '0;
      raB_out   <= '0;
      rdest_out <= '0;
      uop_last  <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      state     <= EXPAND;
      k         <= '0;
      n_last    <= dec_ill ? '0 : dec_last;
      base_a    <= raA;
      base_b    <= raB;
      base_d    <= rdest;
      wide_q    <= widen;
      raA_out   <= raA;
      raB_out   <= raB;
      rdest_out <= rdest;
      uop_last  <= dec_ill || (dec_last == '0);
      illegal   <= dec_ill;
    end else if (fire) begin
      if (uop_last) begin
        state    <= IDLE;
        k        <= '0;
        uop_last <= 1'b0;
        illegal  <= 1'b0;
      end else begin
        k         <= k_nx;
        raA_out   <= base_a + IDX_W'(src_off);
        raB_out   <= base_b + IDX_W'(src_off);
        rdest_out <= base_d + IDX_W'(k_nx);
        uop_last  <= (k_nx == n_last);
      end
    end
  end

endmodule

// File: tb/tb_lmul_group_sequencer.sv
// Scoreboard bench for lmul_group_sequencer.
// Beats expected at accept, compared at handshake.
module tb_lmul_group_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] raA;
  logic [4:0] raB;
  logic [4:0] rdest;
  logic [2:0] lmul_enc;
  logic       widen;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] raA_out;
  logic [4:0] raB_out;
  logic [4:0] rdest_out;
  logic [3:0] uop_idx;
  logic       uop_last;
  logic       illegal;
  logic       fetch_stall;

  always #5 clk = ~clk;

  lmul_group_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .raA         (raA),
    .raB         (raB),
    .rdest       (rdest),
    .lmul_enc    (lmul_enc),
    .widen       (widen),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .raA_out     (raA_out),
    .raB_out     (raB_out),
    .rdest_out   (rdest_out),
    .uop_idx     (uop_idx),
    .uop_last    (uop_last),
    .illegal     (illegal),
    .fetch_stall (fetch_stall)
  );

  typedef struct packed {
    logic       ill;
    logic       last;
    logic [3:0] idx;
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] d;
  } beat_t;

  beat_t sb[$];
  int    n_vec = 0;
  int    n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic expect_instr(input int enc, input bit w,
                              input int a, input int b,
                              input int d);
    int    l;
    int    e;
    bit    bad;
    beat_t x;
    bad = 0;
    case (enc)
      0: l = 1;
      1: l = 2;
      2: l = 4;
      3: l = 8;
      4: begin l = 1; bad = 1; end
      default: l = 1;
    endcase
    e = w ? 2 * l : l;
    if (w && l == 8) bad = 1;
    if ((a % l) != 0 || (b % l) != 0 || (d % e) != 0) bad = 1;
    if (bad) begin
      x.ill  = 1'b1;
      x.last = 1'b1;
      x.idx  = 4'd0;
      x.a    = 5'(a);
      x.b    = 5'(b);
      x.d    = 5'(d);
      sb.push_back(x);
    end else begin
      for (int k = 0; k < e; k++) begin
        x.ill  = 1'b0;
        x.last = (k == e - 1);
        x.idx  = 4'(k);
        x.a    = 5'(a + (w ? k / 2 : k));
        x.b    = 5'(b + (w ? k / 2 : k));
        x.d    = 5'(d + k);
        sb.push_back(x);
      end
    end
  endtask

  task automatic send(input int enc, input bit w, input int a,
                      input int b, input int d, output int waited);
    bit ok;
    ok       = 0;
    waited   = 0;
    lmul_enc = 3'(enc);
    widen    = w;
    raA      = 5'(a);
    raB      = 5'(b);
    rdest    = 5'(d);
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready && !flush && !rst) begin
        expect_instr(enc, w, a, b, d);
        ok = 1;
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", waited, 0);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++)
      @(posedge clk);
    #1;
    chk("drain", sb.size(), 0);
  endtask

  beat_t cur;
  beat_t held;
  beat_t e;
  logic  stall_q = 1'b0;

  // Monitor: compare every handshaked beat, and held beats on stalls
  always @(negedge clk) begin
    cur = {illegal, uop_last, uop_idx, raA_out, raB_out, rdest_out};
    if (rst || flush) begin
      sb.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_beat", cur, held);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("extra_beat", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("beat", cur, e);
          chk("fetch_stall", fetch_stall, !e.last);
          chk("in_ready", in_ready, e.last);
        end
      end
      stall_q = out_valid && !out_ready;
      held    = cur;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  int wt;
  int wsum;

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    raA       = '0;
    raB       = '0;
    rdest     = '0;
    lmul_enc  = '0;
    widen     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_uop_idx", uop_idx, 0);
    chk("rst_uop_last", uop_last, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_fetch_stall", fetch_stall, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_idx", {raA_out, raB_out, rdest_out}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send(2, 0, 8, 12, 4, wt);
    idle();
    drain();

    send(1, 1, 2, 6, 8, wt);
    idle();
    drain();

    send(4, 0, 3, 5, 7, wt);
    send(3, 0, 0, 8, 4, wt);
    send(3, 1, 0, 8, 16, wt);
    idle();
    drain();

    wsum = 0;
    for (int i = 0; i < 8; i++) begin
      send((i % 4 == 0) ? 0 : 4 + (i % 4), 0,
           $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), wt);
      wsum += wt;
    end
    idle();
    chk("stream_wait", wsum, 0);
    drain();

    send(3, 0, 16, 8, 24, wt);
    idle();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    for (int t = 0; t < 2; t++) begin
      send(3, 0, 0, 8, 16, wt);
      idle();
      for (int i = 0; i < 20 && !(out_valid && uop_idx == 2); i++) begin
        @(posedge clk);
        #1;
      end
      chk("reach_beat2", uop_idx, 2);
      if (t == 0) flush = 1'b1;
      else rst = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      rst   = 1'b0;
      chk("kill_out_valid", out_valid, 0);
      chk("kill_in_ready", in_ready, 1);
      chk("kill_fetch_stall", fetch_stall, 0);
      send(2, 0, 4, 4, 4, wt);
      idle();
      drain();
    end

    for (int i = 0; i < 16; i++) begin
      send($urandom_range(0, 7), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) * 8, $urandom_range(0, 7) * 4,
           $urandom_range(0, 15) * 2, wt);
    end
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
